// File: rtl/sram_controller_if.sv
// ----------------------------------------------------------------------------
// sram_controller_if
//   Load/store request bus between the MEM stage and the SRAM controller.
//
//   rd_en       : load request, held until ready
//   wr_en       : store request, held until ready
//   address     : byte address from the ALU result
//   write_data  : store value
//   read_data   : registered load result
//   ready       : 1 = no access pending or access finishing this cycle
//
//   master : the MEM stage (drives requests)
//   slave  : the SRAM controller (answers with read_data / ready)
// ----------------------------------------------------------------------------
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller
//   Memory-side responder for the MEM stage. Each 32-bit load/store is run as
//   two 16-bit accesses (low half, then high half) on an asynchronous SRAM,
//   each half held on the bus for WAIT_CYCLES cycles. ready stays low while an
//   access is in flight so the pipeline freezes.
//
//   Parameters:
//     WAIT_CYCLES : cycles each half is held on the SRAM bus (1..15)
//     BASE_ADDR   : byte address mapped to SRAM word 0
//
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     bus          : request bus (slave side), see sram_controller_if
//     sram_addr    : halfword address to the SRAM (registered)
//     sram_dq_out  : write data to the pad (registered)
//     sram_dq_in   : read data from the pad
//     sram_dq_oe   : pad output enable (registered)
//     sram_we_n    : active-low write strobe (registered)
//     sram_oe_n    : active-low SRAM output enable (registered)
//
//   Optional feature (macro SRAM_LAST_WRITE_FWD_EN):
//     keeps the last written word index and data; a pure read of that index
//     completes in the request cycle without touching the SRAM.
// ----------------------------------------------------------------------------
module sram_controller #(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus,
    output logic [17:0]      sram_addr,
    output logic [15:0]      sram_dq_out,
    input  logic [15:0]      sram_dq_in,
    output logic             sram_dq_oe,
    output logic             sram_we_n,
    output logic             sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        cnt_zero;
    logic        accept;
    logic        ready_c;
    logic        req;
    logic [16:0] req_idx;

    logic        op_wr;
    logic [16:0] idx_q;
    logic [31:0] wdata_q;

    logic        cur_wr;
    logic [16:0] cur_idx;
    logic [31:0] cur_wdata;

    logic [31:0] read_data_q;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    assign req      = bus.rd_en | bus.wr_en;
    assign req_idx  = 17'((bus.address - 32'(BASE_ADDR)) >> 2);
    assign cnt_zero = (cnt == 4'd0);

    // While idle the pad registers are loaded straight from the request so
    // the first half appears on the bus in the cycle after acceptance.
    assign cur_wr    = (state == IDLE) ? bus.wr_en      : op_wr;
    assign cur_idx   = (state == IDLE) ? req_idx        : idx_q;
    assign cur_wdata = (state == IDLE) ? bus.write_data : wdata_q;

`ifdef SRAM_LAST_WRITE_FWD_EN
    logic        fwd_valid;
    logic [16:0] fwd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid <= 1'b0;
        end else if (accept && bus.wr_en) begin
            fwd_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && bus.wr_en) begin
            fwd_idx  <= req_idx;
            fwd_data <= bus.write_data;
        end
    end

    // Store wins over load, so only a pure read may be forwarded.
    assign fwd_hit = (state == IDLE) && bus.rd_en && !bus.wr_en &&
                     fwd_valid && (req_idx == fwd_idx);
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and ready
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = ~req | fwd_hit;
                if (req && !fwd_hit) begin
                    accept    = 1'b1;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (cnt_zero) state_nxt = HIGH;
            end
            HIGH: begin
                if (cnt_zero) state_nxt = DONE;
            end
            DONE: begin
                ready_c   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ready     = ready_c;
    assign bus.read_data = read_data_q;

    // Wait counter and latched operation type
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 4'd0;
            op_wr <= 1'b0;
        end else begin
            if (accept) begin
                op_wr <= bus.wr_en;
            end
            if (accept || ((state == LOW || state == HIGH) && cnt_zero)) begin
                cnt <= CNT_LOAD;
            end else if (state == LOW || state == HIGH) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Latched request data
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_idx;
            wdata_q <= bus.write_data;
        end
    end

    // SRAM pad registers, loaded for the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state_nxt)
                LOW, HIGH: begin
                    sram_addr   <= {cur_idx, state_nxt == HIGH};
                    sram_dq_out <= (state_nxt == HIGH) ? cur_wdata[31:16]
                                                       : cur_wdata[15:0];
                    sram_dq_oe  <= cur_wr;
                    sram_we_n   <= ~cur_wr;
                    sram_oe_n   <= cur_wr;
                end
                default: begin
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                end
            endcase
        end
    end

    // Load result: each half is sampled on the last cycle it is on the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
        end else if (fwd_hit) begin
            read_data_q <= fwd_data;
        end else if (!op_wr && cnt_zero) begin
            if (state == LOW) begin
                read_data_q[15:0] <= sram_dq_in;
            end else if (state == HIGH) begin
                read_data_q[31:16] <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// ----------------------------------------------------------------------------
// tb_sram_controller
//   Self-checking bench for sram_controller: directed scenarios followed by
//   randomized load/store traffic, compared against a word-level memory model.
//   A behavioural asynchronous SRAM is attached to the pad signals.
// ----------------------------------------------------------------------------
module tb_sram_controller;

    localparam int W    = 2;
    localparam int BASE = 1024;
    localparam int NW   = 32;

`ifdef SRAM_LAST_WRITE_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    sram_controller_if bus ();

    sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: edge-sampled write strobe, asynchronous read
    logic [15:0] sram_mem [0:262143];
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];

    // Word-level reference model
    logic [31:0] ref_mem [0:NW-1];
    logic [31:0] ref_rd;
    logic        fv_valid;
    logic [16:0] fv_idx;
    logic [31:0] fv_data;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request (caller is just after a rising edge), wait for ready,
    // step past the completing edge and check everything seen on the way.
    task automatic do_txn(input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic [16:0] idx;
        int          widx;
        logic        hit;
        int          exp_lat;
        int          lat;
        int          we_lo;
        int          oe_lo;
        int          bad;
        logic        done;
        logic        half;

        idx  = 17'((addr - 32'(BASE)) >> 2);
        widx = int'(idx);
        hit  = FWD_ON && rd && !wr && fv_valid && (idx == fv_idx);
        exp_lat = hit ? 0 : 2 * W + 1;

        if (wr) begin
            ref_mem[widx] = wd;
            fv_valid = 1'b1;
            fv_idx   = idx;
            fv_data  = wd;
        end else if (rd) begin
            ref_rd = hit ? fv_data : ref_mem[widx];
        end

        bus.rd_en      = rd;
        bus.wr_en      = wr;
        bus.address    = addr;
        bus.write_data = wd;

        lat = 0; we_lo = 0; oe_lo = 0; bad = 0; done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (k >= 1 && k <= 2 * W) begin
                half = (k > W);
                if (sram_addr !== {idx, half}) bad++;
                if (wr && (!sram_dq_oe ||
                           sram_dq_out !== (half ? wd[31:16] : wd[15:0]))) bad++;
                if (!wr && sram_dq_oe) bad++;
            end
            if (bus.ready) done = 1'b1;
            else lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("we_n_low_cycles", 32'(we_lo), wr ? 32'(2 * W) : 32'd0);
        check_eq("oe_n_low_cycles", 32'(oe_lo), (!wr && !hit) ? 32'(2 * W) : 32'd0);
        check_eq("bus_phase_errors", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        check_eq("read_data", bus.read_data, ref_rd);
    endtask

    task automatic go_idle(input int n);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_read_data"}, bus.read_data, 32'h0);
        check_eq({pfx, "_sram_addr"}, 32'(sram_addr), 32'h0);
        check_eq({pfx, "_sram_dq_out"}, 32'(sram_dq_out), 32'h0);
        check_eq({pfx, "_sram_dq_oe"}, 32'(sram_dq_oe), 32'h0);
        check_eq({pfx, "_sram_we_n"}, 32'(sram_we_n), 32'h1);
        check_eq({pfx, "_sram_oe_n"}, 32'(sram_oe_n), 32'h1);
        check_eq({pfx, "_ready"}, 32'(bus.ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] last_w_addr;
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        int          idx;
        int          old_hi;

        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
        for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
        ref_rd   = 32'h0;
        fv_valid = 1'b0;
        fv_idx   = '0;
        fv_data  = '0;

        rst            = 1'b1;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = 32'h0;
        bus.write_data = 32'h0;

        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed scenarios
        do_txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        go_idle(1);
        do_txn(1'b1, 1'b0, 32'd1024, 32'h0);
        go_idle(2);
        do_txn(1'b1, 1'b1, 32'd1028, 32'h12345678);
        go_idle(1);
        do_txn(1'b1, 1'b0, 32'd1029, 32'h0);
        go_idle(1);
        do_txn(1'b0, 1'b1, 32'd1032, 32'hA5A5_0F0F);
        do_txn(1'b1, 1'b0, 32'd1032, 32'h0);
        go_idle(1);
        do_txn(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D);
        do_txn(1'b1, 1'b0, 32'd1040, 32'h0);
        go_idle(1);

        // Randomized traffic, biased toward re-reading the last store
        last_w_addr = 32'd1040;
        for (int t = 0; t < 60; t++) begin
            op = int'($urandom % 4);
            a  = 32'(BASE) + 32'(($urandom % NW) * 4) + 32'($urandom % 4);
            d  = $urandom;
            if (op <= 1 && ($urandom % 2) == 1) a = last_w_addr;
            case (op)
                0, 1: do_txn(1'b1, 1'b0, a, d);
                2: begin do_txn(1'b0, 1'b1, a, d); last_w_addr = a; end
                default: begin do_txn(1'b1, 1'b1, a, d); last_w_addr = a; end
            endcase
            if (($urandom % 3) == 0) go_idle(1 + int'($urandom % 3));
        end
        go_idle(1);

        // Make read_data non-zero so the reset clear is visible
        ref_mem[7] = 32'h1357_9BDF;
        do_txn(1'b0, 1'b1, 32'd1052, 32'h1357_9BDF);
        do_txn(1'b1, 1'b0, 32'd1052, 32'h0);

        // Reset while the high half of a store is on the bus
        idx    = 9;
        old_hi = int'(ref_mem[idx][31:16]);
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b1;
        bus.address    = 32'(BASE + idx * 4);
        bus.write_data = 32'h7777_8888;
        repeat (3) @(posedge clk);
        #2;
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ref_mem[idx] = {16'(old_hi), 16'h8888};
        ref_rd       = 32'h0;
        fv_valid     = 1'b0;
        do_txn(1'b1, 1'b0, 32'(BASE + idx * 4), 32'h0);
        go_idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side responder for the MEM stage's load/store request interface. Accepts one 32-bit word read or write at a time, executes it as two 16-bit accesses on an external asynchronous SRAM with programmable wait states, and holds `ready` low until the access completes; the pipeline freezes on `~ready`. Sits between the MEM stage and the board SRAM pins, replacing the single-cycle data memory.

## Interface
- `WAIT_CYCLES`, 2: cycles each 16-bit half is held on the SRAM bus; legal range 1..15.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rd_en` input 1: load request; held stable until `ready`.
- `wr_en` input 1: store request; held stable until `ready`.
- `address` input 32: byte address from the ALU result.
- `write_data` input 32: store value.
- `read_data` output 32: registered load result.
- `ready` output 1: combinational; 1 = no access pending or access finishing this cycle.
- `sram_addr` output 18: halfword address, registered.
- `sram_dq_out` output 16: write data to pad, registered.
- `sram_dq_in` input 16: read data from pad.
- `sram_dq_oe` output 1: pad output enable, registered.
- `sram_we_n` output 1: active-low write strobe, registered.
- `sram_oe_n` output 1: active-low output enable, registered.

## Operation
- Word index = (`address` − `BASE_ADDR`) >> 2, low 17 bits; low half at `{idx,0}`, high half at `{idx,1}`. `address[1:0]` ignored; no range check.
- States: IDLE, LOW, HIGH, DONE.
- IDLE: if `wr_en|rd_en`, latch op, address and write data; go LOW, load wait counter with `WAIT_CYCLES`−1. `wr_en` wins when both asserted (read_data unchanged).
- LOW: drive low-half address; write drives `write_data[15:0]`, `sram_dq_oe`=1, `sram_we_n`=0; read drives `sram_oe_n`=0. Counter decrements; at 0 a read captures `sram_dq_in` into `read_data[15:0]`; go HIGH, reload counter.
- HIGH: same with high half / `write_data[31:16]` / `read_data[31:16]`; at 0 go DONE.
- DONE: all SRAM strobes inactive, `ready`=1; go IDLE unconditionally.
- `ready` = ~(`rd_en`|`wr_en`) when IDLE; 0 in LOW and HIGH; 1 in DONE.
- Requests dropped mid-access: access still completes through DONE.
- `read_data` holds its value until the next read completes.

## Timing
- Reset values: `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `sram_oe_n`=1, state IDLE; `ready` follows its combinational rule.
- Request seen in IDLE at cycle 0: `ready`=0 cycles 0..2·WAIT_CYCLES, `ready`=1 at cycle 2·WAIT_CYCLES+1 (DONE); default 5 frozen cycles.
- A request held after DONE (next instruction) is accepted in the following IDLE cycle: one idle-bus cycle between accesses.
- Reset mid-access: immediate return to IDLE, strobes released, partial write possible, `read_data` cleared.
- `sram_we_n` low for exactly WAIT_CYCLES cycles per half; address stable throughout.

## Configuration
- `SRAM_LAST_WRITE_FWD_EN` defined: controller keeps last written word index and data; a read to that index completes in a single cycle (`ready`=1 in the request cycle, `read_data` updated at that edge, no SRAM traffic). Write to any index updates the record; reset invalidates it.
- Undefined: every read takes the full SRAM sequence.

## Test plan
- Reset: assert `rst` mid-HIGH of a write -> all outputs at reset values same cycle, state IDLE, `ready`=1 with no request.
- Write `0xDEADBEEF` to 1024, WAIT_CYCLES=2 -> `sram_addr`=0 with dq 0xBEEF for 2 cycles, then `sram_addr`=1 with 0xDEAD for 2 cycles, `ready` high in cycle 5.
- Read back 1024 from SRAM model -> `read_data`=0xDEADBEEF in DONE, `ready` low exactly 5 cycles.
- Both `rd_en` and `wr_en` at address 1028 value 0x12345678 -> write performed, `read_data` unchanged.
- Back-to-back write 1032 then read 1032 -> second access begins one cycle after DONE, returns written value.
- With `SRAM_LAST_WRITE_FWD_EN`: write 0xCAFEF00D to 1040, read 1040 -> `ready`=1 same cycle, `read_data`=0xCAFEF00D, `sram_oe_n` stays 1.
